btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioner for one raw, active-low button.
// The button is synchronised and debounced in both directions. The block
// reports the debounced level and one-cycle strobes for press, release,
// short press and long press. It also keeps a wrapping count of presses.
//
// Ports
//   clk           system clock, the only clock
//   rst           asynchronous reset, active-high
//   btn_n         raw button, active-low, asynchronous to clk
//   pressed       debounced level, 1 = held
//   press_pulse   one-cycle strobe when a press is accepted
//   release_pulse one-cycle strobe when a release is accepted
//   short_pulse   strobe with release_pulse when the press never became long
//   long_pulse    one-cycle strobe when a held press reaches LONG_CYCLES
//   press_count   accepted presses, modulo 256
//
// state      | meaning
// IDLE       | released and stable
// DB_PRESS   | press seen, counting stable pressed samples
// HELD       | press accepted, counting hold time towards long status
// LONG_HELD  | long status reached, hold counter saturated
// DB_RELEASE | release seen, counting stable released samples
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        LONG_HELD,
        DB_RELEASE
    } state_t;

    state_t        state;
    logic          from_long;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          sync_1;
    logic          sync_2;
    logic          btn_s;

    // The synchroniser resets to "released" so that reset never creates a press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    assign btn_s = ~sync_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            from_long     <= 1'b0;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= DB_PRESS;
                        db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state     <= DB_RELEASE;
                        from_long <= 1'b0;
                        db_cnt    <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= LONG_HELD;
                        long_pulse <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                LONG_HELD: begin
                    if (!btn_s) begin
                        state     <= DB_RELEASE;
                        from_long <= 1'b1;
                        db_cnt    <= '0;
                    end
                end
                DB_RELEASE: begin
                    // A bounce back to pressed resumes where we left off. The hold
                    // counter was frozen, so the long-press timing carries on.
                    if (btn_s) begin
                        state <= from_long ? LONG_HELD : HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                        short_pulse   <= ~from_long;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
